// File: rtl/posit_data_extract_pipe.sv
// Two-stage multi-lane posit decoder: sign/NaR/zero, scale and fraction.
// Optional NaR/zero beat counters under POSIT_EXTRACT_STATS_EN.
module posit_data_extract_pipe #(
  parameter int POSIT_WIDTH = 8,
  parameter int POSIT_ES = 0,
  parameter int NUM_LANES = 1,
  localparam int SCALE_W = POSIT_ES + $clog2(POSIT_WIDTH) + 1,
  localparam int FRAC_W = POSIT_WIDTH - POSIT_ES - 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rts_i,
  output logic                          rtr_o,
  input  logic [NUM_LANES*POSIT_WIDTH-1:0] posit_word_i,
  output logic                          rts_o,
  input  logic                          rtr_i,
  output logic [NUM_LANES-1:0]          sign_o,
  output logic [NUM_LANES-1:0]          inf_o,
  output logic [NUM_LANES-1:0]          zero_o,
  output logic [NUM_LANES*SCALE_W-1:0]  scale_o,
  output logic [NUM_LANES*FRAC_W-1:0]   fraction_o
`ifdef POSIT_EXTRACT_STATS_EN
  ,
  output logic [15:0]                   nar_count_o,
  output logic [15:0]                   zero_count_o
`endif
);

  localparam int N = POSIT_WIDTH;
  localparam int M = POSIT_WIDTH - 1;
  localparam int L = NUM_LANES;

  logic s1_v, s2_v, s1_en, s2_en;
  logic [L-1:0] s1_sign, s1_inf, s1_zero;
  logic [L*M-1:0] s1_mag;

  logic [L-1:0] d1_sign, d1_inf, d1_zero;
  logic [L*M-1:0] d1_mag;
  logic [L*SCALE_W-1:0] d2_scale;
  logic [L*FRAC_W-1:0] d2_frac;

  assign s2_en = ~s2_v | rtr_i;
  assign s1_en = ~s1_v | s2_en;
  assign rtr_o = s1_en;
  assign rts_o = s2_v;

  for (genvar l = 0; l < L; l++) begin : g_lane
    logic [N-1:0] w;
    logic [M-1:0] low;
    logic [M-1:0] body;
    logic [N-4:0] rest;
    logic r0;
    logic [3:0] ex;
    int run;
    int sc;

    assign w = posit_word_i[l*N +: N];
    assign low = w[M-1:0];
    assign d1_sign[l] = w[N-1];
    assign d1_inf[l] = w[N-1] & ~|low;
    assign d1_zero[l] = ~w[N-1] & ~|low;
    assign d1_mag[l*M +: M] = w[N-1] ? (~low + M'(1)) : low;

    assign body = s1_mag[l*M +: M];
    assign r0 = body[M-1];

    always_comb begin : run_len
      logic done;
      run = 0;
      done = 1'b0;
      for (int i = M - 1; i >= 0; i--) begin
        if (!done && body[i] == r0) run = run + 1;
        else done = 1'b1;
      end
    end

    // Drop regime and terminator; the two LSBs are always padding.
    assign rest = (N-3)'((body << (run + 1)) >> 2);

    if (POSIT_ES > 0) begin : g_ex
      assign ex = 4'(rest[N-4 -: POSIT_ES]);
    end else begin : g_nex
      assign ex = '0;
    end

    assign sc = ((r0 ? run - 1 : -run) * (1 << POSIT_ES)) + int'(ex);

    assign d2_scale[l*SCALE_W +: SCALE_W] =
      (s1_inf[l] | s1_zero[l]) ? '0 : SCALE_W'(sc);
    assign d2_frac[l*FRAC_W +: FRAC_W] =
      (s1_inf[l] | s1_zero[l]) ? '0 : rest[FRAC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s1_sign    <= '0;
      s1_inf     <= '0;
      s1_zero    <= '0;
      s1_mag     <= '0;
      s2_v       <= 1'b0;
      sign_o     <= '0;
      inf_o      <= '0;
      zero_o     <= '0;
      scale_o    <= '0;
      fraction_o <= '0;
    end else begin
      if (s1_en) begin
        s1_v <= rts_i;
        if (rts_i) begin
          s1_sign <= d1_sign;
          s1_inf  <= d1_inf;
          s1_zero <= d1_zero;
          s1_mag  <= d1_mag;
        end
      end
      if (s2_en) begin
        s2_v <= s1_v;
        if (s1_v) begin
          sign_o     <= s1_sign;
          inf_o      <= s1_inf;
          zero_o     <= s1_zero;
          scale_o    <= d2_scale;
          fraction_o <= d2_frac;
        end
      end
    end
  end

`ifdef POSIT_EXTRACT_STATS_EN
  int nar_n, zero_n, nar_sum, zero_sum;

  always_comb begin
    nar_n = 0;
    zero_n = 0;
    for (int i = 0; i < L; i++) begin
      nar_n = nar_n + int'(inf_o[i]);
      zero_n = zero_n + int'(zero_o[i]);
    end
  end

  assign nar_sum = int'(nar_count_o) + nar_n;
  assign zero_sum = int'(zero_count_o) + zero_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nar_count_o  <= '0;
      zero_count_o <= '0;
    end else if (rts_o && rtr_i) begin
      nar_count_o  <= (nar_sum > 65535) ? 16'hFFFF : 16'(nar_sum);
      zero_count_o <= (zero_sum > 65535) ? 16'hFFFF : 16'(zero_sum);
    end
  end
`endif

endmodule

// File: tb/tb_posit_data_extract_pipe.sv
// Scoreboard bench for posit_data_extract_pipe: P<8,0> x1 and P<16,2> x2.
// Optional stats ports checked when POSIT_EXTRACT_STATS_EN is defined.
module tb_posit_data_extract_pipe;

  typedef struct packed {
    logic [7:0] w;
    logic s, i, z;
    logic [3:0] sc;
    logic [4:0] fr;
  } vec8_t;

  typedef struct packed {
    logic [31:0] w;
    logic [1:0] s, i, z;
    logic [13:0] sc;
    logic [21:0] fr;
  } vec16_t;

  typedef struct {
    vec8_t v;
    int t0;
    bit lat;
  } exp8_t;

  typedef struct {
    vec16_t v;
    int t0;
  } exp16_t;

  logic clk = 1'b0;
  logic rst_n;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int nar_m = 0;
  int zero_m = 0;

  logic rts8, rtr8_o, rts8_o, rtr8_i;
  logic [7:0] w8;
  logic sign8, inf8, zero8;
  logic [3:0] scale8;
  logic [4:0] frac8;

  logic rts16, rtr16_o, rts16_o, rtr16_i;
  logic [31:0] w16;
  logic [1:0] sign16, inf16, zero16;
  logic [13:0] scale16;
  logic [21:0] frac16;

`ifdef POSIT_EXTRACT_STATS_EN
  logic [15:0] nar8, zc8, nar16, zc16;
`endif

  vec8_t tbl8[12];
  vec16_t tbl16[4];
  exp8_t q8[$];
  exp16_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  posit_data_extract_pipe #(
    .POSIT_WIDTH(8), .POSIT_ES(0), .NUM_LANES(1)
  ) dut8 (
    .clk(clk), .rst_n(rst_n),
    .rts_i(rts8), .rtr_o(rtr8_o), .posit_word_i(w8),
    .rts_o(rts8_o), .rtr_i(rtr8_i),
    .sign_o(sign8), .inf_o(inf8), .zero_o(zero8),
    .scale_o(scale8), .fraction_o(frac8)
`ifdef POSIT_EXTRACT_STATS_EN
    , .nar_count_o(nar8), .zero_count_o(zc8)
`endif
  );

  posit_data_extract_pipe #(
    .POSIT_WIDTH(16), .POSIT_ES(2), .NUM_LANES(2)
  ) dut16 (
    .clk(clk), .rst_n(rst_n),
    .rts_i(rts16), .rtr_o(rtr16_o), .posit_word_i(w16),
    .rts_o(rts16_o), .rtr_i(rtr16_i),
    .sign_o(sign16), .inf_o(inf16), .zero_o(zero16),
    .scale_o(scale16), .fraction_o(frac16)
`ifdef POSIT_EXTRACT_STATS_EN
    , .nar_count_o(nar16), .zero_count_o(zc16)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic send8(input int idx, input bit lat);
    int t;
    bit acc;
    exp8_t e;
    rts8 = 1'b1;
    w8 = tbl8[idx].w;
    t = 0;
    do begin
      @(negedge clk);
      acc = rtr8_o;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 50);
    rts8 = 1'b0;
    if (!acc) chk("send8_timeout", 32'd0, 32'd1);
    else begin
      e.v = tbl8[idx];
      e.t0 = cyc - 1;
      e.lat = lat;
      q8.push_back(e);
    end
  endtask

  task automatic send16(input int idx);
    int t;
    bit acc;
    exp16_t e;
    rts16 = 1'b1;
    w16 = tbl16[idx].w;
    t = 0;
    do begin
      @(negedge clk);
      acc = rtr16_o;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 50);
    rts16 = 1'b0;
    if (!acc) chk("send16_timeout", 32'd0, 32'd1);
    else begin
      e.v = tbl16[idx];
      e.t0 = cyc - 1;
      q16.push_back(e);
    end
  endtask

  // Outputs are checked mid-cycle, ahead of the edge that transfers them.
  always @(negedge clk) begin
    exp8_t e;
    if (rst_n && rts8_o && rtr8_i) begin
      if (q8.size() == 0) chk("sb8_unexpected", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        chk("sign8", 32'(sign8), 32'(e.v.s));
        chk("inf8", 32'(inf8), 32'(e.v.i));
        chk("zero8", 32'(zero8), 32'(e.v.z));
        chk("scale8", 32'(scale8), 32'(e.v.sc));
        chk("frac8", 32'(frac8), 32'(e.v.fr));
        if (e.lat) chk("lat8", 32'(cyc - e.t0), 32'd2);
        nar_m = nar_m + int'(e.v.i);
        zero_m = zero_m + int'(e.v.z);
      end
    end
  end

  always @(negedge clk) begin
    exp16_t e;
    if (rst_n && rts16_o && rtr16_i) begin
      if (q16.size() == 0) chk("sb16_unexpected", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        chk("sign16", 32'(sign16), 32'(e.v.s));
        chk("inf16", 32'(inf16), 32'(e.v.i));
        chk("zero16", 32'(zero16), 32'(e.v.z));
        chk("scale16", 32'(scale16), 32'(e.v.sc));
        chk("frac16", 32'(frac16), 32'(e.v.fr));
        chk("lat16", 32'(cyc - e.t0), 32'd2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    tbl8 = '{
      '{8'h40, 1'b0, 1'b0, 1'b0, 4'h0, 5'b00000},
      '{8'h60, 1'b0, 1'b0, 1'b0, 4'h1, 5'b00000},
      '{8'h50, 1'b0, 1'b0, 1'b0, 4'h0, 5'b10000},
      '{8'hC0, 1'b1, 1'b0, 1'b0, 4'h0, 5'b00000},
      '{8'h80, 1'b1, 1'b1, 1'b0, 4'h0, 5'b00000},
      '{8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 5'b00000},
      '{8'h7F, 1'b0, 1'b0, 1'b0, 4'h6, 5'b00000},
      '{8'h01, 1'b0, 1'b0, 1'b0, 4'hA, 5'b00000},
      '{8'h30, 1'b0, 1'b0, 1'b0, 4'hF, 5'b10000},
      '{8'h4C, 1'b0, 1'b0, 1'b0, 4'h0, 5'b01100},
      '{8'hB4, 1'b1, 1'b0, 1'b0, 4'h0, 5'b01100},
      '{8'h68, 1'b0, 1'b0, 1'b0, 4'h1, 5'b10000}
    };
    tbl16 = '{
      '{32'h7FFF_0001, 2'b00, 2'b00, 2'b00,
        {7'd56, 7'h48}, 22'h0},
      '{32'h5000_4000, 2'b00, 2'b00, 2'b00,
        {7'd2, 7'd0}, 22'h0},
      '{32'h8000_0000, 2'b10, 2'b10, 2'b01,
        14'h0, 22'h0},
      '{32'hFFFF_4A00, 2'b10, 2'b00, 2'b00,
        {7'h48, 7'd1}, {11'h0, 11'h200}}
    };
    rts8 = 1'b0; w8 = '0; rtr8_i = 1'b0;
    rts16 = 1'b0; w16 = '0; rtr16_i = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rts8", 32'(rts8_o), 32'd0);
    chk("rst_out8", {20'h0, sign8, inf8, zero8, scale8, frac8}, 32'd0);
    chk("rst_rts16", 32'(rts16_o), 32'd0);
    chk("rst_scale16", 32'(scale16), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rel_rtr8", 32'(rtr8_o), 32'd1);
    chk("rel_rtr16", 32'(rtr16_o), 32'd1);

    for (int i = 0; i < 4; i++) send16(i);
    repeat (5) @(posedge clk);
    #1;

    rtr8_i = 1'b1;
    send8(0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 1; i < 12; i++) send8(i, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("drain1", 32'(q8.size()), 32'd0);

    rtr8_i = 1'b0;
    fork
      begin
        for (int i = 6; i < 10; i++) send8(i, 1'b0);
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    chk("bp_rtr_o", 32'(rtr8_o), 32'd0);
    chk("bp_rts_o", 32'(rts8_o), 32'd1);
    chk("bp_accepted", 32'(q8.size()), 32'd2);
    snap = {20'h0, sign8, inf8, zero8, scale8, frac8};
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stable", {20'h0, sign8, inf8, zero8, scale8, frac8}, snap);
    rtr8_i = 1'b1;
    wait fork;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_bp", 32'(q8.size()), 32'd0);

    send8(2, 1'b0);
    send8(3, 1'b0);
    #1 rst_n = 1'b0;
    q8.delete();
    nar_m = 0;
    zero_m = 0;
    #1;
    chk("mid_rst_rts", 32'(rts8_o), 32'd0);
    chk("mid_rst_frac", 32'(frac8), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("mid_rel_rtr", 32'(rtr8_o), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("no_stale", 32'(rts8_o), 32'd0);
    send8(4, 1'b1);
    send8(4, 1'b1);
    send8(5, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("drain_end8", 32'(q8.size()), 32'd0);
    chk("drain_end16", 32'(q16.size()), 32'd0);
`ifdef POSIT_EXTRACT_STATS_EN
    chk("nar_count", 32'(nar8), 32'(nar_m));
    chk("zero_count", 32'(zc8), 32'(zero_m));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
